// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_capture
//  Description : Debounces a multiplexed active-low 7-segment bus and
//                assembles the four scanned digits into coherent frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       an_err
);

    localparam logic [7:0]  C_STABLE = 8'(STABLE_CYCLES);
    localparam logic [10:0] C_IDLE   = {4'b1111, 7'h7F};

    logic [10:0]     in_q;
    logic [7:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [3:0][3:0] cap_q, cap_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      mask_q, mask_d;
    logic            fv_q, fv_d, se_q, se_d, ae_q, ae_d;

    logic            w_change, w_accept, w_one_low, w_multi_low;
    logic [3:0]      w_low;
    logic [1:0]      w_pos;
    logic [4:0]      w_dec;

    function automatic logic [4:0] f_decode(input logic [6:0] g);
        case (g)
            7'h40:   return {1'b1, 4'h0};
            7'h79:   return {1'b1, 4'h1};
            7'h24:   return {1'b1, 4'h2};
            7'h30:   return {1'b1, 4'h3};
            7'h19:   return {1'b1, 4'h4};
            7'h12:   return {1'b1, 4'h5};
            7'h02:   return {1'b1, 4'h6};
            7'h78:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h10:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h03:   return {1'b1, 4'hB};
            7'h46:   return {1'b1, 4'hC};
            7'h21:   return {1'b1, 4'hD};
            7'h06:   return {1'b1, 4'hE};
            7'h0E:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    assign w_change = ({an, seg} != in_q);
    // done_q blocks re-acceptance when the counter saturates at STABLE_CYCLES=255
    assign w_accept = (cnt_q == C_STABLE) && !done_q;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (w_change) begin
            cnt_d  = 8'd1;
            done_d = 1'b0;
        end else begin
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
            done_d = done_q | w_accept;
        end
    end

    assign w_low       = ~in_q[10:7];
    assign w_one_low   = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_multi_low = (w_low != 4'd0) && !w_one_low;
    assign w_pos       = w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : w_low[3] ? 2'd3 : 2'd0;
    assign w_dec       = f_decode(in_q[6:0]);

    always_comb begin
        cap_d  = cap_q;
        mask_d = mask_q;
        dig_d  = dig_q;
        fv_d   = 1'b0;
        se_d   = 1'b0;
        ae_d   = 1'b0;
        if (w_accept) begin
            if (w_multi_low) begin
                ae_d = 1'b1;
            end else if (w_one_low) begin
                if (w_dec[4]) begin
                    cap_d[w_pos] = w_dec[3:0];
                    mask_d       = mask_q | w_low;
                    // Completion snapshot includes the value written this edge
                    if (mask_d == 4'b1111) begin
                        dig_d  = cap_d;
                        mask_d = 4'b0000;
                        fv_d   = 1'b1;
                    end
                end else begin
                    se_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q   <= C_IDLE;
            cnt_q  <= 8'd0;
            done_q <= 1'b0;
            cap_q  <= '0;
            dig_q  <= '0;
            mask_q <= 4'b0000;
            fv_q   <= 1'b0;
            se_q   <= 1'b0;
            ae_q   <= 1'b0;
        end else begin
            in_q   <= {an, seg};
            cnt_q  <= cnt_d;
            done_q <= done_d;
            cap_q  <= cap_d;
            dig_q  <= dig_d;
            mask_q <= mask_d;
            fv_q   <= fv_d;
            se_q   <= se_d;
            ae_q   <= ae_d;
        end
    end

    assign digit0      = dig_q[0];
    assign digit1      = dig_q[1];
    assign digit2      = dig_q[2];
    assign digit3      = dig_q[3];
    assign frame_valid = fv_q;
    assign seg_err     = se_q;
    assign an_err      = ae_q;

endmodule
`default_nettype wire

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001: The block SHALL have parameter STABLE_CYCLES, default 2, the number of consecutive clocks {an,seg} must hold unchanged before acceptance; legal range 1..255.
REQ-002: Port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003: Port rst_n, input, 1, asynchronous active-low reset.
REQ-004: Port seg, input, 7, active-low segment lines in bit order {g,f,e,d,c,b,a}.
REQ-005: Port an, input, 4, active-low digit enables; bit N low selects position N.
REQ-006: Ports digit0, digit1, digit2 and digit3, output, 4 bits each, the last complete captured frame.
REQ-007: Port frame_valid, output, 1, a one-cycle pulse when digit0..3 update.
REQ-008: Port seg_err, output, 1, a one-cycle pulse when an accepted pattern is not a legal glyph.
REQ-009: Port an_err, output, 1, a one-cycle pulse when an accepted an value has more than one bit low.

Function
REQ-010: The block SHALL register seg and an once into in_q; all decisions SHALL use in_q only.
REQ-011: An 8-bit saturating stability counter SHALL:
- reload to 1 on any edge where the newly sampled {an,seg} differs from the held in_q;
- otherwise increment.
REQ-012: Acceptance SHALL occur exactly once per dwell, on the edge where the counter reaches STABLE_CYCLES.
- No re-acceptance while inputs stay unchanged.
- A change before that edge restarts the count.
REQ-013: Accept latency: if E0 is the first edge at which in_q captures a new value, the resulting update or pulse SHALL appear at edge E0+STABLE_CYCLES, provided inputs are held through edge E0+STABLE_CYCLES-1.
REQ-014: Glyph decode SHALL use hex values 0..F, listed as 7-bit values in order 0..F:
- 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10, 0x08, 0x03, 0x46, 0x21, 0x06, 0x0E.
- Every other pattern is illegal.
REQ-015: Accept with an having exactly one low bit N and a legal glyph SHALL write the decoded value to internal capture register N and set mask bit N.
REQ-016: Accept with exactly one low bit and an illegal glyph SHALL pulse seg_err with no register or mask change.
REQ-017: Accept with an = 4'b1111 (blanking) SHALL be ignored, with no error.
REQ-018: Accept with two or more low bits SHALL pulse an_err with no register or mask change.
REQ-019: A repeat capture of position N before frame completion SHALL overwrite capture register N, keeping the latest value.
REQ-020: Position capture order SHALL be irrelevant.
REQ-021: When an accept makes mask = 4'b1111, the same edge SHALL:
- copy all four captures, including the just-written value, to digit0..3;
- assert frame_valid for one cycle;
- clear the mask to 0.
REQ-022: digit0..3 SHALL change only on frame completion, so they always form a coherent snapshot.
REQ-023: frame_valid, seg_err and an_err SHALL be mutually exclusive in any cycle.

Reset
REQ-024: While rst_n is low the block SHALL hold:
- digit0..3 = 0, capture registers = 0, mask = 0;
- frame_valid, seg_err, an_err = 0;
- in_q = {an=4'b1111, seg=7'h7F};
- stability counter = 0.
REQ-025: Reset asserted mid-frame SHALL discard partial captures; after release a full four-position frame is required before the next frame_valid.
REQ-026: The first sampled value after release SHALL be treated as a change, reloading the counter to 1.

Verification
REQ-027: Scenario, normal frame:
- Stimulus: STABLE_CYCLES=2; drive an=1110/seg=0x40, 1101/0x79, 1011/0x24, 0111/0x30, 4 clocks each.
- Required: a single frame_valid pulse; digit0..3 = 0,1,2,3.
REQ-028: Scenario, glitch:
- Stimulus: position 0 shows 0x19 for 1 clock, then 0x12 for 4 clocks; other positions legal.
- Required: digit0 = 5 at frame_valid; no seg_err.
REQ-029: Scenario, illegal glyph:
- Stimulus: an=1011 with seg=0x7F held 3 clocks.
- Required: exactly one seg_err pulse at E0+2; mask unchanged; no frame_valid.
REQ-030: Scenario, overlap and blanking:
- Stimulus: an=1100 held 5 clocks, then an=1111 held 5 clocks.
- Required: exactly one an_err pulse; no other pulses.
REQ-031: Scenario, reset mid-frame:
- Stimulus: positions 0..2 captured, rst_n pulsed low, then only position 3 driven.
- Required: no frame_valid; digits read 0.
REQ-032: Scenario, STABLE_CYCLES=1 with back-to-back 1-clock dwells on all four positions.
- Required: every position accepted.
- Required: frame_valid at the edge after the fourth value is sampled.
